// File: rtl/axis_rx_packer_if.sv
// AXI-Stream byte-packed word bus leaving the receive packer.
// The packer drives the master side; the downstream consumer uses the slave side.
interface axis_rx_packer_if #(
  parameter int LOGIC_SIZE = 32
);
  logic [LOGIC_SIZE-1:0]   s_axis_tdata;
  logic [LOGIC_SIZE/8-1:0] s_axis_tkeep;
  logic                    s_axis_tlast;
  logic                    s_axis_valid;
  logic                    s_axis_ready;

  modport master (
    output s_axis_tdata,
    output s_axis_tkeep,
    output s_axis_tlast,
    output s_axis_valid,
    input  s_axis_ready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tkeep,
    input  s_axis_tlast,
    input  s_axis_valid,
    output s_axis_ready
  );
endinterface

// File: rtl/axis_rx_packer.sv
// Receive framer/packer: hunts for K28.5 comma alignment, then packs decoded
// bytes between SOF (K27.7) and EOF (K29.7) into LOGIC_SIZE-bit AXIS words,
// first byte in lane 0. A 2-entry output FIFO absorbs AXIS backpressure
// because the decoder byte stream cannot be stalled.
// Optional feature macro: AXIS_RX_PACKER_ERRCNT_EN enables the saturating
// code-error counter on o_err_count (tied to zero otherwise).
module axis_rx_packer #(
  parameter int LOGIC_SIZE  = 32,
  parameter int COMMA_COUNT = 4,
  parameter int LOS_ERRS    = 4
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_reset_n,
  input  logic [7:0]            i_from_decoder,
  input  logic                  i_is_k,
  input  logic                  i_dec_valid,
  input  logic                  i_code_err,
  axis_rx_packer_if.master      axis,
  output logic                  o_aligned,
  output logic                  o_overflow,
  output logic [15:0]           o_err_count
);

  localparam int NB    = LOGIC_SIZE / 8;
  localparam int IDX_W = $clog2(NB);
  localparam int CC_W  = $clog2(COMMA_COUNT + 1);
  localparam int LE_W  = $clog2(LOS_ERRS + 1);

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SOF   = 8'hFB;
  localparam logic [7:0] K_EOF   = 8'hFD;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Byte-valid mask for a partial word holding n bytes (lanes 0..n-1).
  function automatic logic [NB-1:0] keep_mask(input logic [IDX_W-1:0] n);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [CC_W-1:0]       r_comma_cnt, w_comma_nxt;
  logic [LE_W-1:0]       r_los_cnt, w_los_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [LOGIC_SIZE-1:0] r_acc, w_acc_nxt;
  logic                  r_aligned;

  logic                  w_push, w_push_last, w_err, w_pop;
  logic [LOGIC_SIZE-1:0] w_push_data;
  logic [NB-1:0]         w_push_keep;

  logic [1:0]            r_cnt;
  logic                  r_valid, r_ovf;
  logic [LOGIC_SIZE-1:0] r_data0, r_data1;
  logic [NB-1:0]         r_keep0, r_keep1;
  logic                  r_last0, r_last1;

  // Framer state register and alignment flag (tracks the state it enters).
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_reset_n) begin
      r_state     <= ST_HUNT;
      r_comma_cnt <= '0;
      r_los_cnt   <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_aligned   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_comma_cnt <= w_comma_nxt;
      r_los_cnt   <= w_los_nxt;
      r_idx       <= w_idx_nxt;
      r_acc       <= w_acc_nxt;
      r_aligned   <= (w_state_nxt != ST_HUNT);
    end
  end

  // Next-state, packing and FIFO-push decode for one decoded symbol.
  always_comb begin
    w_state_nxt = r_state;
    w_comma_nxt = r_comma_cnt;
    w_los_nxt   = r_los_cnt;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    w_push      = 1'b0;
    w_push_data = r_acc;
    w_push_keep = keep_mask(r_idx);
    w_push_last = 1'b1;
    w_err       = 1'b0;
    if (i_dec_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (i_is_k && (i_from_decoder == K_COMMA) && !i_code_err) begin
            if (r_comma_cnt == CC_W'(COMMA_COUNT - 1)) begin
              w_state_nxt = ST_IDLE;
              w_comma_nxt = '0;
            end else begin
              w_comma_nxt = r_comma_cnt + CC_W'(1);
            end
          end else begin
            w_comma_nxt = '0;
          end
        end
        ST_IDLE: begin
          if (i_code_err) begin
            w_err = 1'b1;
          end else if (!i_is_k || (i_from_decoder == K_COMMA)) begin
            w_state_nxt = ST_IDLE;
          end else if (i_from_decoder == K_SOF) begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = '0;
            w_acc_nxt   = '0;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_DATA: begin
          if (i_code_err) begin
            w_err = 1'b1;
          end else if (!i_is_k) begin
            w_acc_nxt[{r_idx, 3'b000} +: 8] = i_from_decoder;
            if (r_idx == IDX_W'(NB - 1)) begin
              w_push      = 1'b1;
              w_push_data = w_acc_nxt;
              w_push_keep = '1;
              w_push_last = 1'b0;
              w_idx_nxt   = '0;
              w_acc_nxt   = '0;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else if (i_from_decoder == K_COMMA) begin
            w_state_nxt = ST_DATA;
          end else if ((i_from_decoder == K_EOF) || (i_from_decoder == K_SOF)) begin
            // SOF closes the running frame like EOF and immediately reopens one.
            w_push      = 1'b1;
            w_idx_nxt   = '0;
            w_acc_nxt   = '0;
            w_state_nxt = (i_from_decoder == K_EOF) ? ST_IDLE : ST_DATA;
          end else begin
            w_err = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_comma_nxt = '0;
        end
      endcase
      // Loss-of-alignment: a run of erroring symbols drops back to HUNT,
      // flushing any partial frame with tlast so the consumer sees a boundary.
      if (r_state != ST_HUNT) begin
        if (w_err) begin
          if (r_los_cnt == LE_W'(LOS_ERRS - 1)) begin
            w_push      = (r_state == ST_DATA);
            w_state_nxt = ST_HUNT;
            w_comma_nxt = '0;
            w_los_nxt   = '0;
            w_idx_nxt   = '0;
            w_acc_nxt   = '0;
          end else begin
            w_los_nxt = r_los_cnt + LE_W'(1);
          end
        end else begin
          w_los_nxt = '0;
        end
      end else begin
        w_los_nxt = '0;
      end
    end else begin
      w_los_nxt = r_los_cnt;
    end
  end

  assign w_pop = r_valid && axis.s_axis_ready;

  // Two-entry output FIFO; entry 0 drives the AXIS outputs directly so they
  // stay stable under backpressure and read as zero when empty.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_reset_n) begin
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_data0 <= '0;
      r_keep0 <= '0;
      r_last0 <= 1'b0;
      r_data1 <= '0;
      r_keep1 <= '0;
      r_last1 <= 1'b0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (w_push) begin
            r_data0 <= w_push_data;
            r_keep0 <= w_push_keep;
            r_last0 <= w_push_last;
            r_cnt   <= 2'd1;
            r_valid <= 1'b1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_data0 <= w_push_data;
            r_keep0 <= w_push_keep;
            r_last0 <= w_push_last;
          end else if (w_pop) begin
            r_data0 <= '0;
            r_keep0 <= '0;
            r_last0 <= 1'b0;
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
          end else if (w_push) begin
            r_data1 <= w_push_data;
            r_keep1 <= w_push_keep;
            r_last1 <= w_push_last;
            r_cnt   <= 2'd2;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_data0 <= r_data1;
            r_keep0 <= r_keep1;
            r_last0 <= r_last1;
            r_data1 <= w_push ? w_push_data : '0;
            r_keep1 <= w_push ? w_push_keep : '0;
            r_last1 <= w_push ? w_push_last : 1'b0;
            r_cnt   <= w_push ? 2'd2 : 2'd1;
          end else if (w_push) begin
            r_ovf <= 1'b1;
          end
        end
        default: begin
          r_cnt   <= 2'd0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign axis.s_axis_tdata = r_data0;
  assign axis.s_axis_tkeep = r_keep0;
  assign axis.s_axis_tlast = r_last0;
  assign axis.s_axis_valid = r_valid;
  assign o_aligned         = r_aligned;
  assign o_overflow        = r_ovf;

`ifdef AXIS_RX_PACKER_ERRCNT_EN
  logic [15:0] r_err_cnt;

  // Saturating count of erroring symbols seen while aligned.
  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_reset_n) begin
      r_err_cnt <= 16'd0;
    end else if (w_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  assign o_err_count = r_err_cnt;
`else
  assign o_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_axis_rx_packer.sv
// Scoreboard bench for axis_rx_packer: a byte/queue level reference model
// predicts every AXIS beat, and a negedge monitor checks beats as they leave.
module tb_axis_rx_packer;
  localparam int LS = 32;
  localparam int NB = LS / 8;

  typedef struct packed {
    logic [LS-1:0] data;
    logic [NB-1:0] keep;
    logic          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  dec_byte;
  logic        is_k, dec_valid, code_err;
  logic        aligned, overflow;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  axis_rx_packer_if #(.LOGIC_SIZE(LS)) axis_if ();

  axis_rx_packer #(.LOGIC_SIZE(LS), .COMMA_COUNT(4), .LOS_ERRS(4)) dut (
    .s_axis_aclk    (clk),
    .s_axis_reset_n (rst_n),
    .i_from_decoder (dec_byte),
    .i_is_k         (is_k),
    .i_dec_valid    (dec_valid),
    .i_code_err     (code_err),
    .axis           (axis_if),
    .o_aligned      (aligned),
    .o_overflow     (overflow),
    .o_err_count    (err_count)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    beats   = 0;
  beat_t exp_q[$];

  // Reference model state: 0=hunting, 1=aligned idle, 2=inside a frame.
  int          m_mode, m_commas, m_run, m_errs, m_occ;
  bit          m_ovf;
  logic [7:0]  m_frame[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t pack_frame(input bit last);
    beat_t b;
    b.data = '0;
    foreach (m_frame[i]) b.data[i*8 +: 8] = m_frame[i];
    b.keep = last ? NB'((1 << m_frame.size()) - 1) : {NB{1'b1}};
    b.last = last;
    return b;
  endfunction

  function automatic int exp_errs();
`ifdef AXIS_RX_PACKER_ERRCNT_EN
    return m_errs;
`else
    return 0;
`endif
  endfunction

  task automatic model_symbol(input logic [7:0] b, input bit k, input bit e,
                              output bit have, output beat_t w);
    bit bad;
    have = 0;
    w    = '0;
    if (m_mode == 0) begin
      if (k && b == 8'hBC && !e) begin
        m_commas++;
        if (m_commas == 4) begin m_mode = 1; m_commas = 0; end
      end else m_commas = 0;
      return;
    end
    bad = e || (k && !(b inside {8'hBC, 8'hFB, 8'hFD})) || (m_mode == 1 && k && b == 8'hFD);
    if (bad) begin
      if (m_errs < 65535) m_errs++;
      m_run++;
      if (m_run == 4) begin
        if (m_mode == 2) begin w = pack_frame(1); have = 1; end
        m_mode = 0; m_commas = 0; m_run = 0; m_frame.delete();
      end
      return;
    end
    m_run = 0;
    if (!k) begin
      if (m_mode == 2) begin
        m_frame.push_back(b);
        if (m_frame.size() == NB) begin w = pack_frame(0); have = 1; m_frame.delete(); end
      end
    end else if (b == 8'hFB) begin
      if (m_mode == 2) begin w = pack_frame(1); have = 1; end
      m_frame.delete();
      m_mode = 2;
    end else if (b == 8'hFD) begin
      w = pack_frame(1); have = 1; m_frame.delete(); m_mode = 1;
    end
  endtask

  task automatic model_cycle(input bit v, input logic [7:0] b, input bit k, input bit e,
                             input bit rdy, input bit rstn);
    bit    pop, have;
    beat_t w;
    if (!rstn) begin
      m_mode = 0; m_commas = 0; m_run = 0; m_errs = 0; m_occ = 0; m_ovf = 0;
      m_frame.delete();
      exp_q.delete();
      return;
    end
    pop  = (m_occ > 0) && rdy;
    have = 0;
    if (pop) m_occ--;
    if (v) model_symbol(b, k, e, have, w);
    if (have) begin
      if (m_occ < 2) begin exp_q.push_back(w); m_occ++; end
      else m_ovf = 1;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit k, input bit e,
                      input bit rdy, input bit rstn);
    @(posedge clk); #1;
    rst_n = rstn; dec_valid = v; dec_byte = b; is_k = k; code_err = e;
    axis_if.s_axis_ready = rdy;
    model_cycle(v, b, k, e, rdy, rstn);
  endtask

  task automatic sym_d(input logic [7:0] b, input bit rdy); step(1, b, 0, 0, rdy, 1); endtask
  task automatic sym_k(input logic [7:0] b, input bit rdy); step(1, b, 1, 0, rdy, 1); endtask
  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, rdy, 1);
  endtask
  task automatic do_reset();
    step(0, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 1);
  endtask

  task automatic check_status(input string name, input bit rdy);
    step(0, 8'h00, 0, 0, rdy, 1);
    @(negedge clk);
    chk({name, "_aligned"}, aligned, (m_mode != 0));
    chk({name, "_overflow"}, overflow, m_ovf);
    chk({name, "_errcnt"}, err_count, exp_errs());
  endtask

  task automatic check_zero_outputs(input string name);
    @(negedge clk);
    chk({name, "_valid"}, axis_if.s_axis_valid, 0);
    chk({name, "_tlast"}, axis_if.s_axis_tlast, 0);
    chk({name, "_tkeep"}, axis_if.s_axis_tkeep, 0);
    chk({name, "_tdata"}, axis_if.s_axis_tdata, 0);
    chk({name, "_aligned"}, aligned, 0);
    chk({name, "_overflow"}, overflow, 0);
    chk({name, "_errcnt"}, err_count, 0);
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stability under stall.
  beat_t held;
  bit    stall = 0;
  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{data: axis_if.s_axis_tdata, keep: axis_if.s_axis_tkeep, last: axis_if.s_axis_tlast};
    if (axis_if.s_axis_valid) begin
      if (stall) chk("hold_stable", cur, held);
      if (axis_if.s_axis_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got data 0x%0h keep 0x%0h last %0b, expected no beat",
                   cur.data, cur.keep, cur.last);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", cur.data, e.data);
          chk("beat_keep", cur.keep, e.keep);
          chk("beat_last", cur.last, e.last);
        end
        stall = 0;
      end else begin
        stall = 1;
        held  = cur;
      end
    end else begin
      stall = 0;
    end
  end

  initial begin
    int b0, r;
    bit rdy;
    rst_n = 0; dec_valid = 0; dec_byte = 8'h00; is_k = 0; code_err = 0;
    axis_if.s_axis_ready = 0;
    step(0, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 1);
    check_zero_outputs("reset");

    // Basic frame with a full word and a null-byte terminator.
    for (int i = 0; i < 4; i++) sym_k(8'hBC, 1);
    sym_k(8'hFB, 1);
    sym_d(8'h11, 1); sym_d(8'h22, 1); sym_d(8'h33, 1); sym_d(8'h44, 1);
    sym_k(8'hFD, 1);
    idle(1, 3);
    check_status("t1", 1);
    chk("t1_aligned_spec", aligned, 1);
    chk("t1_drained", exp_q.size(), 0);

    // Short frame: partial word.
    sym_k(8'hFB, 1); sym_d(8'hAA, 1); sym_d(8'hBB, 1); sym_k(8'hFD, 1);
    idle(1, 3);
    chk("t2_drained", exp_q.size(), 0);

    // Backpressure: two words held, third push overflows.
    sym_k(8'hFB, 0);
    for (int i = 0; i < 12; i++) sym_d(8'(i + 1), 0);
    sym_k(8'hFD, 0);
    idle(0, 2);
    check_status("t3", 0);
    chk("t3_ovf_spec", overflow, 1);
    b0 = beats;
    idle(1, 6);
    chk("t3_beats", beats - b0, 2);

    // Loss of alignment mid-frame flushes the partial word.
    do_reset();
    for (int i = 0; i < 4; i++) sym_k(8'hBC, 1);
    sym_k(8'hFB, 1); sym_d(8'h01, 1);
    for (int i = 0; i < 4; i++) step(1, 8'($urandom_range(0, 255)), 0, 1, 1, 1);
    idle(1, 3);
    check_status("t4", 1);
    chk("t4_aligned_spec", aligned, 0);
    chk("t4_drained", exp_q.size(), 0);

    // Broken comma run does not align; a clean run of four does.
    do_reset();
    for (int i = 0; i < 3; i++) sym_k(8'hBC, 1);
    sym_d(8'h00, 1);
    for (int i = 0; i < 3; i++) sym_k(8'hBC, 1);
    check_status("t5a", 1);
    chk("t5a_aligned_spec", aligned, 0);
    sym_k(8'hBC, 1);
    check_status("t5b", 1);
    chk("t5b_aligned_spec", aligned, 1);

    // Reset mid-frame with two words buffered.
    sym_k(8'hFB, 0);
    for (int i = 0; i < 9; i++) sym_d(8'(8'h50 + i), 0);
    do_reset();
    check_zero_outputs("t6");
    b0 = beats;
    sym_k(8'hFB, 1); sym_d(8'h11, 1); sym_d(8'h22, 1); sym_k(8'hFD, 1);
    idle(1, 3);
    chk("t6_hunt_no_beats", beats - b0, 0);
    chk("t6_aligned", aligned, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 4; i++) sym_k(8'hBC, 1);
    for (int n = 0; n < 4000; n++) begin
      r   = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 9) < 7);
      if (m_mode == 0 && r < 90) sym_k(8'hBC, rdy);
      else if (r < 8)  step(0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), rdy, 1);
      else if (r < 58) sym_d(8'($urandom_range(0, 255)), rdy);
      else if (r < 68) sym_k(8'hBC, rdy);
      else if (r < 76) sym_k(8'hFB, rdy);
      else if (r < 84) sym_k(8'hFD, rdy);
      else if (r < 88) sym_k(8'h1C, rdy);
      else if (r < 92) step(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1, rdy, 1);
      else sym_d(8'($urandom_range(0, 255)), rdy);
    end
    idle(1, 10);
    check_status("rand", 1);
    chk("rand_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
